// File: rtl/pudiannao_pkg.sv
// pudiannao_pkg: shared ColdBuffer geometry constants and the loader state type
package pudiannao_pkg;
  localparam int MLU_NUM = 16;
  localparam int FEAT_NUM = 16;
  localparam int ROW_WORDS = MLU_NUM * FEAT_NUM;
  localparam int CB_ROWS = 128;
  localparam int BEAT_WORDS = 16;
  localparam int CB_IDX_W = 7;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, FINISH} loader_state_t;
endpackage

// File: rtl/cold_buffer_loader_if.sv
// cold_buffer_loader_if: cmd/mem/ColdBuffer handshake bundle; slave = loader side, master = driver side
interface cold_buffer_loader_if #(
  parameter int BEAT_WORDS = 16,
  parameter int ROW_WORDS = 256
);
  logic cmd_valid;
  logic cmd_ready;
  logic [pudiannao_pkg::CB_IDX_W-1:0] cmd_base_row;
  logic [7:0] cmd_num_rows;
  logic mem_valid;
  logic mem_ready;
  logic [BEAT_WORDS-1:0][31:0] mem_data;
  logic cb_write_en;
  logic cb_read_en;
  logic [pudiannao_pkg::CB_IDX_W-1:0] cb_idx;
  logic [ROW_WORDS-1:0][31:0] cb_data;
  logic busy;
  logic done;
  logic err;
  modport slave (
    input cmd_valid, cmd_base_row, cmd_num_rows, mem_valid, mem_data,
    output cmd_ready, mem_ready, cb_write_en, cb_read_en, cb_idx, cb_data, busy, done, err
  );
  modport master (
    output cmd_valid, cmd_base_row, cmd_num_rows, mem_valid, mem_data,
    input cmd_ready, mem_ready, cb_write_en, cb_read_en, cb_idx, cb_data, busy, done, err
  );
endinterface

// File: rtl/cb_row_packer.sv
// cb_row_packer: stages beats 0..n-2 (ports clk, rst, load, beat_idx, beat_data -> row) and publishes the whole row on the last beat so row only changes once per row
module cb_row_packer #(
  parameter int BEAT_WORDS = 16,
  parameter int ROW_WORDS = 256,
  localparam int BEATS = ROW_WORDS / BEAT_WORDS,
  localparam int IW = $clog2(BEATS)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [IW-1:0] beat_idx,
  input  logic [BEAT_WORDS-1:0][31:0] beat_data,
  output logic [ROW_WORDS-1:0][31:0] row
);
  logic [ROW_WORDS-BEAT_WORDS-1:0][31:0] stage;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stage <= '0;
      row <= '0;
    end else if (load) begin
      if (beat_idx == IW'(BEATS - 1)) row <= {beat_data, stage};
      else stage[beat_idx*BEAT_WORDS +: BEAT_WORDS] <= beat_data;
    end
endmodule

// File: rtl/cold_buffer_loader.sv
// cold_buffer_loader: loads cmd_num_rows ColdBuffer rows from 16-word memory beats (ports clk, rst, bus: cmd/mem/cb handshake, busy/done/err)
module cold_buffer_loader #(
  parameter int BEAT_WORDS = pudiannao_pkg::BEAT_WORDS,
  parameter int ROW_WORDS = pudiannao_pkg::ROW_WORDS,
  parameter int CB_ROWS = pudiannao_pkg::CB_ROWS
) (
  input logic clk,
  input logic rst,
  cold_buffer_loader_if.slave bus
);
  import pudiannao_pkg::*;
  localparam int BEATS = ROW_WORDS / BEAT_WORDS;
  localparam int BW = $clog2(BEATS);
  loader_state_t state;
  logic [BW-1:0] beat;
  logic [7:0] rows_left;
  logic [CB_IDX_W-1:0] cur_row;
  logic bad;
  logic illegal;
  logic load;
  logic [ROW_WORDS-1:0][31:0] row;
  assign illegal = bus.cmd_num_rows == 8'd0 || bus.cmd_num_rows > 8'(CB_ROWS);
  assign load = state == FILL && bus.mem_valid && bus.mem_ready;
  assign bus.cb_read_en = 1'b0;
  assign bus.cb_data = row;
  cb_row_packer #(.BEAT_WORDS(BEAT_WORDS), .ROW_WORDS(ROW_WORDS)) u_pack (
    .clk(clk), .rst(rst), .load(load), .beat_idx(beat), .beat_data(bus.mem_data), .row(row)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      beat <= '0;
      rows_left <= '0;
      cur_row <= '0;
      bad <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.cb_write_en <= 1'b0;
      bus.cb_idx <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else case (state)
      IDLE: begin
        bus.cmd_ready <= 1'b1;
        if (bus.cmd_valid && bus.cmd_ready) begin
          cur_row <= bus.cmd_base_row;
          rows_left <= bus.cmd_num_rows;
          bad <= illegal;
          beat <= '0;
          bus.cmd_ready <= 1'b0;
          bus.busy <= 1'b1;
          bus.mem_ready <= !illegal;
          bus.done <= illegal;
          bus.err <= illegal;
          state <= illegal ? FINISH : FILL;
        end
      end
      FILL: if (load) begin
        beat <= beat + 1'b1;
        if (beat == BW'(BEATS - 1)) begin
          state <= WRITE;
          bus.mem_ready <= 1'b0;
          bus.cb_write_en <= 1'b1;
          bus.cb_idx <= cur_row;
        end
      end
      WRITE: begin
        bus.cb_write_en <= 1'b0;
        cur_row <= cur_row + 1'b1;
        rows_left <= rows_left - 1'b1;
        beat <= '0;
        bus.mem_ready <= rows_left != 8'd1;
        bus.done <= rows_left == 8'd1;
        bus.err <= bad && rows_left == 8'd1;
        state <= rows_left == 8'd1 ? FINISH : FILL;
      end
      FINISH: begin
        bus.done <= 1'b0;
        bus.err <= 1'b0;
        bus.busy <= 1'b0;
        bus.cmd_ready <= 1'b1;
        state <= IDLE;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_cold_buffer_loader.sv
// tb_cold_buffer_loader: scoreboard bench for cold_buffer_loader
module tb_cold_buffer_loader;
  typedef logic [255:0][31:0] row_t;
  typedef struct {logic [6:0] idx; row_t data; int cyc;} wr_t;
  typedef struct {logic [6:0] idx; int pat;} exp_t;
  typedef struct {int cyc; logic err;} dn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, total = 0, bad = 0, beats = 0, mr = 0, to_flag = 0, acc = 0;
  logic poke_rdy = 1'b0;
  wr_t wq[$];
  exp_t exp_q[$];
  dn_t dq[$];
  wr_t w;
  exp_t e;
  cold_buffer_loader_if bus();
  cold_buffer_loader dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.cb_write_en) wq.push_back('{bus.cb_idx, bus.cb_data, cyc});
    if (bus.done) dq.push_back('{cyc, bus.err});
    if (bus.mem_valid && bus.mem_ready) beats++;
    if (bus.mem_ready) mr++;
  end
  function automatic logic [31:0] wv(int pat, int k);
    return 32'((pat << 12) + k);
  endfunction
  function automatic row_t exp_row(int pat);
    row_t r;
    for (int k = 0; k < 256; k++) r[k] = wv(pat, k);
    return r;
  endfunction
  function automatic int diff(row_t a, row_t b);
    for (int k = 0; k < 256; k++) if (a[k] !== b[k]) return k;
    return 0;
  endfunction
  task automatic clear_obs();
    wq.delete();
    dq.delete();
    exp_q.delete();
    beats = 0;
    mr = 0;
    to_flag = 0;
    poke_rdy = 1'b0;
  endtask
  task automatic next_write();
    if (wq.size() > 0) w = wq.pop_front();
    else begin
      w.idx = 'x;
      w.data = 'x;
      w.cyc = -1;
    end
  endtask
  task automatic run_cmd(input logic [6:0] base, input logic [7:0] num, input int pat, input bit stall, input bit poke, input int stop);
    int n, lim, t;
    logic v;
    @(negedge clk);
    bus.cmd_base_row = base;
    bus.cmd_num_rows = num;
    bus.cmd_valid = 1'b1;
    t = 0;
    while (!bus.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) to_flag++;
    acc = cyc;
    lim = (num == 0 || num > 128) ? 0 : int'(num) * 16;
    if (stop >= 0) lim = stop;
    n = 0;
    t = 0;
    while (n < lim && t < 5000) begin
      @(negedge clk);
      t++;
      bus.cmd_valid = poke && n >= 3 && n < 6;
      if (bus.cmd_valid) begin
        bus.cmd_base_row = 7'd99;
        bus.cmd_num_rows = 8'd3;
        poke_rdy = poke_rdy | bus.cmd_ready;
      end
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.mem_valid = v;
      for (int l = 0; l < 16; l++) bus.mem_data[l] = wv(pat + n / 16, (n % 16) * 16 + l);
      if (v && bus.mem_ready) n++;
    end
    if (n < lim) to_flag++;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.busy && t < 400);
    if (bus.busy) to_flag++;
    @(negedge clk);
  endtask
  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.cmd_base_row = '0;
    bus.cmd_num_rows = '0;
    bus.mem_data = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.cmd_ready, bus.mem_ready, bus.cb_write_en, bus.cb_read_en, bus.busy, bus.done, bus.err} !== 7'b0) begin
      bad++;
      $display("FAIL reset ctrl: got %b want 0000000", {bus.cmd_ready, bus.mem_ready, bus.cb_write_en, bus.cb_read_en, bus.busy, bus.done, bus.err});
    end
    total++;
    if (bus.cb_idx !== 7'd0) begin bad++; $display("FAIL reset cb_idx: got %0d want 0", bus.cb_idx); end
    total++;
    if (bus.cb_data !== '0) begin bad++; $display("FAIL reset cb_data: word %0d got %h want 0", diff(bus.cb_data, '0), bus.cb_data[diff(bus.cb_data, '0)]); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL release: cmd_ready/busy got %b%b want 10", bus.cmd_ready, bus.busy); end
  endtask
  task automatic test_single_row();
    clear_obs();
    exp_q.push_back('{7'd5, 0});
    run_cmd(7'd5, 8'd1, 0, 0, 0, -1);
    wait_idle();
    e = exp_q.pop_front();
    next_write();
    total++;
    if (w.idx !== e.idx) begin bad++; $display("FAIL single idx: got %0d want %0d", w.idx, e.idx); end
    total++;
    if (w.data !== exp_row(e.pat)) begin bad++; $display("FAIL single data: word %0d got %h want %h", diff(w.data, exp_row(e.pat)), w.data[diff(w.data, exp_row(e.pat))], wv(e.pat, diff(w.data, exp_row(e.pat)))); end
    total++;
    if (w.cyc - acc !== 17) begin bad++; $display("FAIL single latency: got %0d want 17", w.cyc - acc); end
    total++;
    if (wq.size() !== 0 || dq.size() !== 1 || to_flag !== 0) begin bad++; $display("FAIL single counts: extra_writes=%0d dones=%0d timeouts=%0d want 0 1 0", wq.size(), dq.size(), to_flag); end
    if (dq.size() > 0) begin
      total++;
      if (dq[0].cyc !== w.cyc + 1 || dq[0].err !== 1'b0) begin bad++; $display("FAIL single done: cyc %0d err %b want cyc %0d err 0", dq[0].cyc, dq[0].err, w.cyc + 1); end
    end
  endtask
  task automatic test_wrap();
    clear_obs();
    for (int r = 0; r < 4; r++) exp_q.push_back('{7'(126 + r), 2 + r});
    run_cmd(7'd126, 8'd4, 2, 0, 0, -1);
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_write();
      total++;
      if (w.idx !== e.idx || w.data !== exp_row(e.pat)) begin bad++; $display("FAIL wrap write: idx %0d word0 %h want idx %0d word0 %h", w.idx, w.data[0], e.idx, wv(e.pat, 0)); end
    end
    total++;
    if (wq.size() !== 0 || dq.size() !== 1 || to_flag !== 0) begin bad++; $display("FAIL wrap counts: extra_writes=%0d dones=%0d timeouts=%0d want 0 1 0", wq.size(), dq.size(), to_flag); end
  endtask
  task automatic test_back_pressure();
    clear_obs();
    exp_q.push_back('{7'd0, 0});
    exp_q.push_back('{7'd1, 1});
    run_cmd(7'd0, 8'd2, 0, 1, 0, -1);
    wait_idle();
    total++;
    if (wq.size() !== 2 || beats !== 32) begin bad++; $display("FAIL bp counts: writes=%0d beats=%0d want 2 32", wq.size(), beats); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_write();
      total++;
      if (w.idx !== e.idx || w.data !== exp_row(e.pat)) begin bad++; $display("FAIL bp write: idx %0d word %0d got %h want idx %0d", w.idx, diff(w.data, exp_row(e.pat)), w.data[diff(w.data, exp_row(e.pat))], e.idx); end
    end
    total++;
    if (dq.size() !== 1 || to_flag !== 0) begin bad++; $display("FAIL bp done: dones=%0d timeouts=%0d want 1 0", dq.size(), to_flag); end
  endtask
  task automatic test_illegal();
    logic [7:0] nums [2];
    nums[0] = 8'd0;
    nums[1] = 8'd200;
    for (int i = 0; i < 2; i++) begin
      clear_obs();
      run_cmd(7'd3, nums[i], 0, 0, 0, -1);
      wait_idle();
      total++;
      if (dq.size() !== 1 || wq.size() !== 0 || mr !== 0 || to_flag !== 0) begin bad++; $display("FAIL illegal %0d counts: dones=%0d writes=%0d mem_ready_cycles=%0d timeouts=%0d want 1 0 0 0", nums[i], dq.size(), wq.size(), mr, to_flag); end
      if (dq.size() > 0) begin
        total++;
        if (dq[0].err !== 1'b1 || dq[0].cyc !== acc + 1) begin bad++; $display("FAIL illegal %0d done: err %b cyc %0d want err 1 cyc %0d", nums[i], dq[0].err, dq[0].cyc, acc + 1); end
      end
    end
  endtask
  task automatic test_reset_abort();
    clear_obs();
    run_cmd(7'd0, 8'd1, 7, 0, 0, 8);
    total++;
    if (wq.size() !== 0 || beats !== 8) begin bad++; $display("FAIL abort pre: writes=%0d beats=%0d want 0 8", wq.size(), beats); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || wq.size() !== 0 || dq.size() !== 0) begin bad++; $display("FAIL abort post: cmd_ready=%b writes=%0d dones=%0d want 1 0 0", bus.cmd_ready, wq.size(), dq.size()); end
    clear_obs();
    exp_q.push_back('{7'd10, 9});
    run_cmd(7'd10, 8'd1, 9, 0, 0, -1);
    wait_idle();
    e = exp_q.pop_front();
    next_write();
    total++;
    if (w.idx !== e.idx || w.data !== exp_row(e.pat) || wq.size() !== 0 || dq.size() !== 1) begin bad++; $display("FAIL abort new: idx %0d extra_writes %0d dones %0d want idx 10 0 1", w.idx, wq.size(), dq.size()); end
  endtask
  task automatic test_cmd_busy();
    clear_obs();
    exp_q.push_back('{7'd20, 4});
    run_cmd(7'd20, 8'd1, 4, 0, 1, -1);
    wait_idle();
    total++;
    if (poke_rdy !== 1'b0) begin bad++; $display("FAIL busy cmd_ready: got %b want 0", poke_rdy); end
    e = exp_q.pop_front();
    next_write();
    total++;
    if (w.idx !== e.idx || w.data !== exp_row(e.pat) || wq.size() !== 0 || dq.size() !== 1 || to_flag !== 0) begin bad++; $display("FAIL busy run: idx %0d extra_writes %0d dones %0d timeouts %0d want idx 20 0 1 0", w.idx, wq.size(), dq.size(), to_flag); end
  endtask
  initial begin
    test_reset();
    test_single_row();
    test_wrap();
    test_back_pressure();
    test_illegal();
    test_reset_abort();
    test_cmd_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
